flits_tx: RTL
=============

# flits_tx

Packet transmitter for the NIC's outbound path: wb slave side → NoC router. It accepts one fully assembled packet (up to MAX_PACKET_LENGHT flits) from the message source, latches it, and serializes it flit by flit onto the router input link. Flow control toward the router's flits buffer uses credits (`credit_signal_i`) and the buffer busy→idle indication (`free_signal_i`). It is the transmitting counterpart of the NIC's flits buffer receiver.

## Interface
- FLIT_WIDTH, 32, bits per flit.
- MAX_PACKET_LENGHT, 8, maximum flits per packet.
- N_BITS_POINTER, 3, flit index width; clog2(MAX_PACKET_LENGHT).
- N_BITS_LENGHT, 4, length field width; clog2(MAX_PACKET_LENGHT+1).
- N_CREDITS, 8, depth of the router-side flits buffer, i.e. the initial credit count.
- N_BITS_CREDIT, 4, credit counter width; clog2(N_CREDITS+1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- r_msg_to_pkt_i  in  1  source requests transmission of the packet on `in_link_i`.
- g_msg_to_pkt_o  out  1  grant; packet latched on this edge.
- in_link_i  in  MAX_PACKET_LENGHT*FLIT_WIDTH  packet; flit k at [k*FLIT_WIDTH +: FLIT_WIDTH], flit 0 = head.
- packet_lenght_i  in  N_BITS_LENGHT  number of valid flits.
- out_link_o  out  FLIT_WIDTH  flit to router.
- is_valid_o  out  1  high when `out_link_o` carries a valid flit.
- credit_signal_i  in  1  router freed one buffer slot this cycle.
- free_signal_i  in  1  router buffer went busy→idle.
- busy_o  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, SEND, WAIT_FREE.
- IDLE: `g_msg_to_pkt_o = r_msg_to_pkt_i` (combinational, IDLE only). On a grant edge:
  - latch `in_link_i` into the packet register;
  - latch the length, clamped: 0→1, >MAX_PACKET_LENGHT→MAX_PACKET_LENGHT;
  - clear the pointer to 0;
  - go to SEND.
- SEND: a flit is issued on an edge when credit_cnt>0. Issuing a flit:
  - registers flit[ptr] to `out_link_o` and sets `is_valid_o`=1;
  - increments ptr.
  
  If credit_cnt==0, no flit is issued and `is_valid_o`=0. After the flit at index length-1 is issued, go to WAIT_FREE.
- WAIT_FREE: `is_valid_o`=0. On `free_signal_i`=1, go to IDLE. This enforces one outstanding packet in the router buffer.
- `free_signal_i` is ignored in IDLE and SEND.
- Credit counter:
  - next = cnt − issue + `credit_signal_i`, evaluated in every state;
  - saturates at N_CREDITS; a return while full is dropped;
  - never goes below 0, because issue requires cnt>0.
- `g_msg_to_pkt_o` is 0 in SEND and WAIT_FREE. Changes to `in_link_i` and `packet_lenght_i` after the grant have no effect.
- `out_link_o` holds its last value when `is_valid_o`=0.

## Timing
- Reset values:
  - state IDLE; `g_msg_to_pkt_o`=0 unless a request is present;
  - `out_link_o`=0, `is_valid_o`=0, `busy_o`=0;
  - credit_cnt=N_CREDITS, ptr=0.
- Latency: grant in cycle 0 → head flit valid in cycle 1. With sufficient credits, an L-flit packet occupies cycles 1..L back-to-back.
- `busy_o` is registered from state: 1 from cycle 1 until the cycle after `free_signal_i` is sampled in WAIT_FREE.
- Earliest next grant: the cycle after `free_signal_i` is seen in WAIT_FREE.
- Credits: a `credit_signal_i` in cycle n makes that credit usable for the issue edge at the end of cycle n+1. A simultaneous issue and return at cnt=1 leaves cnt=1, and issue continues.
- Reset mid-operation: on the next edge, FSM→IDLE, `is_valid_o`=0, credits=N_CREDITS. The partial packet is discarded with no further flits.

## Test plan
- Reset, then a 3-flit request with flits 0xA0,0xA1,0xA2 and full credits:
  - grant in cycle 0; `is_valid_o` in cycles 1–3 with 0xA0,0xA1,0xA2;
  - `is_valid_o`=0 in cycle 4; a second request is not granted;
  - `free_signal_i` pulse in cycle 6 → next request granted in cycle 7.
- N_CREDITS=2, 4-flit packet, no credit returns:
  - flits 0 and 1 in cycles 1–2, then `is_valid_o`=0;
  - `credit_signal_i` in cycle 5 → flit 2 in cycle 7;
  - a second credit → flit 3.
- Credit return in the same cycle as an issue at cnt=1: cnt stays 1 and flits remain back-to-back. 5 extra returns while cnt=N_CREDITS: cnt stays N_CREDITS.
- Length clamping:
  - `packet_lenght_i`=0 → exactly 1 flit (flit 0);
  - `packet_lenght_i`=12 with MAX=8 → exactly 8 flits, indices 0..7.
- Changing `in_link_i` during SEND:
  - the originally latched flits are transmitted;
  - a request held high in SEND/WAIT_FREE gets `g_msg_to_pkt_o`=0.
- `rst` pulsed after flit 1 of a 5-flit packet:
  - `is_valid_o`=0 from the next cycle, credits=N_CREDITS, `busy_o`=0;
  - a new request is granted the cycle after reset deasserts, and its head flit appears one cycle later.

Source files
------------

// File: rtl/flits_tx.sv
// flits_tx: latches one assembled packet from the message source and serializes
// it flit by flit onto the router input link under credit-based flow control.
module flits_tx #(
    parameter int unsigned FLIT_WIDTH        = 32,
    parameter int unsigned MAX_PACKET_LENGHT = 8,
    parameter int unsigned N_BITS_POINTER    = 3,
    parameter int unsigned N_BITS_LENGHT     = 4,
    parameter int unsigned N_CREDITS         = 8,
    parameter int unsigned N_BITS_CREDIT     = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    r_msg_to_pkt_i,
    output logic                                    g_msg_to_pkt_o,
    input  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] in_link_i,
    input  logic [N_BITS_LENGHT-1:0]                packet_lenght_i,
    output logic [FLIT_WIDTH-1:0]                   out_link_o,
    output logic                                    is_valid_o,
    input  logic                                    credit_signal_i,
    input  logic                                    free_signal_i,
    output logic                                    busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_FREE = 2'd2
    } state_t;

    state_t                     r_state;
    logic [FLIT_WIDTH-1:0]      r_pkt [MAX_PACKET_LENGHT];
    logic [N_BITS_POINTER-1:0]  r_ptr;
    logic [N_BITS_LENGHT-1:0]   r_len;
    logic [N_BITS_CREDIT-1:0]   r_credit;
    logic [FLIT_WIDTH-1:0]      r_out;
    logic                       r_valid;
    logic                       r_busy;

    logic                       w_grant;
    logic                       w_issue;
    logic                       w_last;
    logic [N_BITS_LENGHT-1:0]   w_len_clamped;
    logic [N_BITS_LENGHT-1:0]   w_len_eff;
    logic [N_BITS_POINTER-1:0]  w_idx;
    logic [FLIT_WIDTH-1:0]      w_flit;
    logic [N_BITS_CREDIT-1:0]   w_credit_next;

    // Grant is only offered while idle.
    assign w_grant = (r_state == ST_IDLE) && r_msg_to_pkt_i;

    // Clamp the requested length into 1..MAX_PACKET_LENGHT.
    always_comb begin
        w_len_clamped = packet_lenght_i;
        if (packet_lenght_i == '0) begin
            w_len_clamped = N_BITS_LENGHT'(1);
        end else if (packet_lenght_i > N_BITS_LENGHT'(MAX_PACKET_LENGHT)) begin
            w_len_clamped = N_BITS_LENGHT'(MAX_PACKET_LENGHT);
        end
    end

    // The head flit is taken straight from in_link_i on the grant edge so it
    // appears the very next cycle; later flits come from the packet register.
    always_comb begin
        w_issue   = (r_credit != '0) && (w_grant || (r_state == ST_SEND));
        w_idx     = w_grant ? '0 : r_ptr;
        w_len_eff = w_grant ? w_len_clamped : r_len;
        w_flit    = w_grant ? in_link_i[FLIT_WIDTH-1:0] : r_pkt[r_ptr];
        w_last    = (N_BITS_LENGHT'(w_idx) == (w_len_eff - N_BITS_LENGHT'(1)));
    end

    // Credit counter: minus one per issued flit, plus one per return, saturating.
    always_comb begin
        w_credit_next = r_credit;
        if (w_issue && !credit_signal_i) begin
            w_credit_next = r_credit - N_BITS_CREDIT'(1);
        end else if (!w_issue && credit_signal_i &&
                     (r_credit != N_BITS_CREDIT'(N_CREDITS))) begin
            w_credit_next = r_credit + N_BITS_CREDIT'(1);
        end
    end

    // Packet storage, written only on the grant edge.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            for (int k = 0; k < int'(MAX_PACKET_LENGHT); k++) begin
                r_pkt[k] <= in_link_i[k*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

    // Transmit FSM with registered flit, valid and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_len    <= '0;
            r_credit <= N_BITS_CREDIT'(N_CREDITS);
            r_out    <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_credit <= w_credit_next;
            r_valid  <= w_issue;
            if (w_issue) begin
                r_out <= w_flit;
            end
            case (r_state)
                ST_IDLE: begin
                    r_busy <= w_grant;
                    if (w_grant) begin
                        r_len <= w_len_clamped;
                        r_ptr <= w_issue ? N_BITS_POINTER'(1) : '0;
                        r_state <= (w_issue && w_last) ? ST_WAIT_FREE : ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_busy <= 1'b1;
                    if (w_issue) begin
                        r_ptr <= r_ptr + N_BITS_POINTER'(1);
                        if (w_last) begin
                            r_state <= ST_WAIT_FREE;
                        end
                    end
                end
                ST_WAIT_FREE: begin
                    r_busy <= !free_signal_i;
                    if (free_signal_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign g_msg_to_pkt_o = w_grant;
    assign out_link_o     = r_out;
    assign is_valid_o     = r_valid;
    assign busy_o         = r_busy;

endmodule
